// File: rtl/uart_tx_buf_if.sv
// Byte-enqueue handshake and serial/status outputs of the buffered UART transmitter.
interface uart_tx_buf_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          uart_txd;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, uart_txd, tx_busy, fifo_count
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, uart_txd, tx_busy, fifo_count
  );
endinterface

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO; frames go out back-to-back
// while the FIFO holds data.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) for BAUD_CNT cycles
// DATA  | 8 data bits LSB first, BAUD_CNT cycles each
// STOP  | stop bit (1); last cycle pops the next byte or returns to IDLE
module uart_tx_buf #(
  parameter int BPS        = 230400,
  parameter int CLK_FRE    = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  uart_tx_buf_if.slave bus
);
  localparam int BAUD_CNT = CLK_FRE / BPS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_CNT + 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic          baud_done;
  logic          have_data;

  // Ready comes from the registered count only, so a full FIFO rejects a push
  // even on the edge where the transmitter pops.
  assign push      = bus.tx_valid && (count_q != FULL);
  assign baud_done = (baud_q == '0);
  assign have_data = (count_q != '0);

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_LAST;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (!baud_done) begin
          baud_d = baud_q - BW'(1);
        end else if (have_data) begin
          // Chain straight into the next start bit: no idle gap on the line.
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_LAST;
          txd_d   = 1'b0;
          state_d = START;
        end else begin
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.uart_txd   = txd_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_ready   = (count_q != FULL);
  assign bus.fifo_count = count_q;
endmodule
